// File: rtl/octane_pkg.sv
// Shared definitions for the operator phase scheduler.
//   SINE_ARG_WIDTH    : width of the argument handed to the shared sine unit
//   SINE_RESULT_WIDTH : width of the signed sample returned by the sine unit
//   sched_state_e     : scheduler FSM states
package octane_pkg;

    localparam int unsigned SINE_ARG_WIDTH    = 13;
    localparam int unsigned SINE_RESULT_WIDTH = 18;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } sched_state_e;

endpackage

// File: rtl/phase_accumulator_bank.sv
// Per-slot step and phase register arrays.
//   clk_i, rst_ni : clock, asynchronous active-low reset (clears phases and steps)
//   rd_slot_i     : slot whose current (pre-increment) phase is presented on rd_phase_o
//   acc_en_i      : accumulate phase[acc_slot_i] += step[acc_slot_i] at this edge
//   cfg_we_i      : write cfg_step_i into step[cfg_slot_i]; the accumulate reads the old step
module phase_accumulator_bank #(
    parameter int unsigned NUM_SLOTS   = 32,
    parameter int unsigned PHASE_WIDTH = 24,
    localparam int unsigned SLOT_W     = $clog2(NUM_SLOTS)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [SLOT_W-1:0]      rd_slot_i,
    output logic [PHASE_WIDTH-1:0] rd_phase_o,
    input  logic                   acc_en_i,
    input  logic [SLOT_W-1:0]      acc_slot_i,
    input  logic                   cfg_we_i,
    input  logic [SLOT_W-1:0]      cfg_slot_i,
    input  logic [PHASE_WIDTH-1:0] cfg_step_i
);

    logic [PHASE_WIDTH-1:0] phase_q [NUM_SLOTS];
    logic [PHASE_WIDTH-1:0] phase_d [NUM_SLOTS];
    logic [PHASE_WIDTH-1:0] step_q  [NUM_SLOTS];
    logic [PHASE_WIDTH-1:0] step_d  [NUM_SLOTS];

    assign rd_phase_o = phase_q[rd_slot_i];

    always_comb begin
        phase_d = phase_q;
        step_d  = step_q;
        // Both use step_q, so a same-edge config write only affects later reads.
        if (acc_en_i) begin
            phase_d[acc_slot_i] = phase_q[acc_slot_i] + step_q[acc_slot_i];
        end
        if (cfg_we_i && (32'(cfg_slot_i) < NUM_SLOTS)) begin
            step_d[cfg_slot_i] = cfg_step_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                phase_q[i] <= '0;
                step_q[i]  <= '0;
            end
        end else begin
            phase_q <= phase_d;
            step_q  <= step_d;
        end
    end

endmodule

// File: rtl/operator_phase_scheduler.sv
// Time-multiplexes one shared sine unit across NUM_SLOTS operator slots, one frame per tick.
//   i_Clock, i_Reset_n        : clock, asynchronous active-low reset
//   i_SampleTick              : starts a frame when idle; while busy it only sets o_Overrun
//   i_CfgWrite/Slot/Step      : per-slot phase increment configuration
//   o_SineArgument/IssueSlot  : argument and slot tag presented to the sine unit
//   i_SineResult              : sine unit output, SINE_LATENCY edges after sampling
//   o_Result/ResultSlot/Valid : realigned sample with its slot tag
//   o_FrameDone, o_Busy, o_Overrun : frame status
// Optional feature macro OCTANE_PHASE_MOD_EN adds i_PhaseMod, added to the argument only.
module operator_phase_scheduler
    import octane_pkg::*;
#(
    parameter int unsigned NUM_SLOTS    = 32,
    parameter int unsigned PHASE_WIDTH  = 24,
    parameter int unsigned SINE_LATENCY = 3,
    localparam int unsigned SLOT_W      = $clog2(NUM_SLOTS)
) (
    input  logic                                i_Clock,
    input  logic                                i_Reset_n,
    input  logic                                i_SampleTick,
    input  logic                                i_CfgWrite,
    input  logic [SLOT_W-1:0]                   i_CfgSlot,
    input  logic [PHASE_WIDTH-1:0]              i_CfgStep,
`ifdef OCTANE_PHASE_MOD_EN
    input  logic [SINE_ARG_WIDTH-1:0]           i_PhaseMod,
`endif
    output logic [SINE_ARG_WIDTH-1:0]           o_SineArgument,
    input  logic signed [SINE_RESULT_WIDTH-1:0] i_SineResult,
    output logic [SLOT_W-1:0]                   o_IssueSlot,
    output logic signed [SINE_RESULT_WIDTH-1:0] o_Result,
    output logic [SLOT_W-1:0]                   o_ResultSlot,
    output logic                                o_ResultValid,
    output logic                                o_FrameDone,
    output logic                                o_Busy,
    output logic                                o_Overrun
);

    localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(NUM_SLOTS - 1);
    localparam int unsigned       DRAIN_W    = $clog2(SINE_LATENCY + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(SINE_LATENCY);

    sched_state_e                   state_q, state_d;
    logic [SLOT_W-1:0]              slot_q, slot_d;
    logic [DRAIN_W-1:0]             drain_q, drain_d;
    logic [SINE_ARG_WIDTH-1:0]      arg_q, arg_d;
    logic                           overrun_q, overrun_d;
    logic                           frame_done_q, frame_done_d;
    logic                           res_valid_q, res_valid_d;
    logic signed [SINE_RESULT_WIDTH-1:0] result_q, result_d;
    logic [SLOT_W-1:0]              res_slot_q, res_slot_d;
    // Valid/tag delay line matching the sine unit latency.
    logic [SINE_LATENCY-1:0]        vld_sr_q, vld_sr_d;
    logic [SLOT_W-1:0]              tag_sr_q [SINE_LATENCY];
    logic [SLOT_W-1:0]              tag_sr_d [SINE_LATENCY];

    logic                           start;
    logic                           issue_next;
    logic [SLOT_W-1:0]              next_slot;
    logic [PHASE_WIDTH-1:0]         rd_phase;
    logic [SINE_ARG_WIDTH-1:0]      rd_top;

    // The FrameDone cycle is still treated as busy for tick purposes.
    assign start      = (state_q == IDLE) && i_SampleTick && !frame_done_q;
    assign issue_next = start || ((state_q == RUN) && (slot_q != LAST_SLOT));
    assign next_slot  = start ? '0 : slot_q + SLOT_W'(1);
    assign rd_top     = rd_phase[PHASE_WIDTH-1 -: SINE_ARG_WIDTH];

    // The argument for the next slot is registered from its pre-increment phase; that slot's
    // phase (and step read) is updated at the end of its own issue cycle.
    phase_accumulator_bank #(
        .NUM_SLOTS   (NUM_SLOTS),
        .PHASE_WIDTH (PHASE_WIDTH)
    ) u_bank (
        .clk_i      (i_Clock),
        .rst_ni     (i_Reset_n),
        .rd_slot_i  (next_slot),
        .rd_phase_o (rd_phase),
        .acc_en_i   (state_q == RUN),
        .acc_slot_i (slot_q),
        .cfg_we_i   (i_CfgWrite),
        .cfg_slot_i (i_CfgSlot),
        .cfg_step_i (i_CfgStep)
    );

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        drain_d      = drain_q;
        arg_d        = arg_q;
        overrun_d    = overrun_q;
        frame_done_d = 1'b0;
        result_d     = result_q;
        res_slot_d   = res_slot_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (slot_q == LAST_SLOT) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue_next) begin
            slot_d = next_slot;
`ifdef OCTANE_PHASE_MOD_EN
            arg_d  = rd_top + i_PhaseMod;
`else
            arg_d  = rd_top;
`endif
        end

        if (i_SampleTick && ((state_q != IDLE) || frame_done_q)) begin
            overrun_d = 1'b1;
        end

        vld_sr_d[0] = (state_q == RUN);
        tag_sr_d[0] = slot_q;
        for (int unsigned i = 1; i < SINE_LATENCY; i++) begin
            vld_sr_d[i] = vld_sr_q[i-1];
            tag_sr_d[i] = tag_sr_q[i-1];
        end

        res_valid_d = vld_sr_q[SINE_LATENCY-1];
        if (vld_sr_q[SINE_LATENCY-1]) begin
            result_d   = i_SineResult;
            res_slot_d = tag_sr_q[SINE_LATENCY-1];
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            drain_q      <= '0;
            arg_q        <= '0;
            overrun_q    <= 1'b0;
            frame_done_q <= 1'b0;
            res_valid_q  <= 1'b0;
            result_q     <= '0;
            res_slot_q   <= '0;
            vld_sr_q     <= '0;
            for (int unsigned i = 0; i < SINE_LATENCY; i++) begin
                tag_sr_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            drain_q      <= drain_d;
            arg_q        <= arg_d;
            overrun_q    <= overrun_d;
            frame_done_q <= frame_done_d;
            res_valid_q  <= res_valid_d;
            result_q     <= result_d;
            res_slot_q   <= res_slot_d;
            vld_sr_q     <= vld_sr_d;
            tag_sr_q     <= tag_sr_d;
        end
    end

    assign o_SineArgument = arg_q;
    assign o_IssueSlot    = slot_q;
    assign o_Result       = result_q;
    assign o_ResultSlot   = res_slot_q;
    assign o_ResultValid  = res_valid_q;
    assign o_FrameDone    = frame_done_q;
    assign o_Busy         = (state_q != IDLE);
    assign o_Overrun      = overrun_q;

endmodule

// File: tb/tb_operator_phase_scheduler.sv
// Bench for operator_phase_scheduler with NUM_SLOTS=4, PHASE_WIDTH=24 and a 3-edge sine model.
// Define OCTANE_PHASE_MOD_EN to also exercise the phase modulation input.
module tb_operator_phase_scheduler;

    localparam int unsigned N        = 4;
    localparam int unsigned L        = 3;
    localparam int unsigned DONE_CYC = N + L + 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              tick;
    logic              cfg_we;
    logic [1:0]        cfg_slot;
    logic [23:0]       cfg_step;
    logic [12:0]       pm;
    logic [12:0]       arg;
    logic signed [17:0] sres;
    logic [1:0]        issue;
    logic signed [17:0] res;
    logic [1:0]        res_slot;
    logic              valid, done, busy, ovr;
    logic signed [17:0] p1, p2, p3;

    int checks = 0;
    int errors = 0;

    logic [23:0] mphase [N];
    logic [23:0] mstep  [N];
    logic [12:0] frame_args [N];
    logic [12:0] obs_args   [N];
    logic [12:0] s1_args [3];
    logic [12:0] s2_args [3];

    always #5 clk = ~clk;

    operator_phase_scheduler #(
        .NUM_SLOTS    (N),
        .PHASE_WIDTH  (24),
        .SINE_LATENCY (L)
    ) dut (
        .i_Clock        (clk),
        .i_Reset_n      (rst_n),
        .i_SampleTick   (tick),
        .i_CfgWrite     (cfg_we),
        .i_CfgSlot      (cfg_slot),
        .i_CfgStep      (cfg_step),
`ifdef OCTANE_PHASE_MOD_EN
        .i_PhaseMod     (pm),
`endif
        .o_SineArgument (arg),
        .i_SineResult   (sres),
        .o_IssueSlot    (issue),
        .o_Result       (res),
        .o_ResultSlot   (res_slot),
        .o_ResultValid  (valid),
        .o_FrameDone    (done),
        .o_Busy         (busy),
        .o_Overrun      (ovr)
    );

    function automatic logic signed [17:0] sine_f(input logic [12:0] a);
        return {~a[4:0], a};
    endfunction

    function automatic logic [12:0] top13(input logic [23:0] p);
        return p[23:11];
    endfunction

    // Sine unit: samples the argument and presents the result three edges later.
    always_ff @(posedge clk) begin
        p1 <= sine_f(arg);
        p2 <= p1;
        p3 <= p2;
    end
    assign sres = p3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input int slot, input logic [23:0] v);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_slot = 2'(slot);
        cfg_step = v;
        mstep[slot] = v;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n  = 1'b0;
        tick   = 1'b0;
        cfg_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            mphase[i] = '0;
            mstep[i]  = '0;
        end
    endtask

    // One frame, checked every cycle from T+1 to the FrameDone cycle.
    task automatic run_frame(input bit rnd_cfg, input bit tick_at_done);
        int s;
        int w;
        logic [23:0] v;
        logic [17:0] er;
        bit exp_valid;
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        for (int cyc = 1; cyc <= DONE_CYC; cyc++) begin
            if (cyc > 1) @(negedge clk);
            cfg_we = 1'b0;
            s = cyc - 1;
            if (cyc <= N) begin
                frame_args[s] = top13(mphase[s]) + pm;
                obs_args[s]   = arg;
                chk($sformatf("issue_slot c%0d", cyc), 32'(issue), 32'(s));
                chk($sformatf("argument c%0d", cyc), 32'(arg), 32'(frame_args[s]));
            end else begin
                chk($sformatf("issue_hold c%0d", cyc), 32'(issue), 32'(N - 1));
                chk($sformatf("arg_hold c%0d", cyc), 32'(arg), 32'(frame_args[N-1]));
            end
            exp_valid = (cyc >= L + 2) && (cyc <= N + L + 1);
            chk($sformatf("result_valid c%0d", cyc), 32'(valid), 32'(exp_valid));
            if (exp_valid) begin
                er = sine_f(frame_args[cyc-L-2]);
                chk($sformatf("result_slot c%0d", cyc), 32'(res_slot), 32'(cyc - L - 2));
                chk($sformatf("result c%0d", cyc), 32'($unsigned(res)), 32'(er));
            end
            chk($sformatf("busy c%0d", cyc), 32'(busy), 32'(cyc <= N + L + 1));
            chk($sformatf("frame_done c%0d", cyc), 32'(done), 32'(cyc == DONE_CYC));
            if (cyc <= N) mphase[s] = mphase[s] + mstep[s];
            if (rnd_cfg && ($urandom_range(0, 2) == 0)) begin
                w = int'($urandom_range(0, N - 1));
                v = 24'($urandom);
                cfg_we   = 1'b1;
                cfg_slot = 2'(w);
                cfg_step = v;
                mstep[w] = v;
            end
            if (tick_at_done && (cyc == DONE_CYC)) tick = 1'b1;
        end
        @(negedge clk);
        tick   = 1'b0;
        cfg_we = 1'b0;
        if (tick_at_done) begin
            chk("tick_in_done_ignored", 32'(busy), 32'(0));
            chk("overrun_from_done_tick", 32'(ovr), 32'(1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        int nd;
        rst_n = 1'b0; tick = 1'b0; cfg_we = 1'b0; cfg_slot = '0; cfg_step = '0; pm = '0;
        for (int i = 0; i < N; i++) begin
            mphase[i] = '0;
            mstep[i]  = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(valid), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_overrun", 32'(ovr), 32'(0));
        chk("rst_arg", 32'(arg), 32'(0));
        chk("rst_issue", 32'(issue), 32'(0));
        chk("rst_result", 32'($unsigned(res)), 32'(0));
        chk("rst_result_slot", 32'(res_slot), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'(0));

        // Known steps on slots 1 and 2, random on the others.
        cfg_write(1, 24'h010000);
        cfg_write(2, 24'h800000);
        cfg_write(0, 24'($urandom));
        cfg_write(3, 24'($urandom));
        for (int f = 0; f < 3; f++) begin
            run_frame(1'b0, 1'b0);
            s1_args[f] = obs_args[1];
            s2_args[f] = obs_args[2];
        end
        chk("slot1_f0", 32'(s1_args[0]), 32'h000);
        chk("slot1_f1", 32'(s1_args[1]), 32'h020);
        chk("slot1_f2", 32'(s1_args[2]), 32'h040);
        chk("slot2_f0", 32'(s2_args[0]), 32'h0000);
        chk("slot2_f1", 32'(s2_args[1]), 32'h1000);
        chk("slot2_f2", 32'(s2_args[2]), 32'h0000);
        chk("no_overrun", 32'(ovr), 32'(0));

        // Random config traffic during frames, including writes in issue cycles.
        repeat (5) run_frame(1'b1, 1'b0);
        chk("no_overrun_rand", 32'(ovr), 32'(0));

        // Tick in the FrameDone cycle is an overrun and starts nothing.
        run_frame(1'b1, 1'b1);

        // Tick while busy at T+3.
        reset_dut();
        chk("overrun_cleared", 32'(ovr), 32'(0));
        for (int i = 0; i < N; i++) cfg_write(i, 24'($urandom));
        @(negedge clk);
        tick = 1'b1;
        nv = 0;
        nd = 0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            tick = (cyc == 3);
            nv += int'(valid);
            nd += int'(done);
        end
        tick = 1'b0;
        chk("overrun_valid_count", 32'(nv), 32'(N));
        chk("overrun_done_count", 32'(nd), 32'(1));
        chk("overrun_sticky", 32'(ovr), 32'(1));
        chk("overrun_idle", 32'(busy), 32'(0));
        for (int i = 0; i < N; i++) mphase[i] = mphase[i] + mstep[i];
        run_frame(1'b0, 1'b0);
        chk("overrun_still_set", 32'(ovr), 32'(1));

        // Reset asserted at T+3.
        @(negedge clk);
        tick = 1'b1;
        nv = 0;
        nd = 0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            tick = 1'b0;
            if (cyc == 3) rst_n = 1'b0;
            if (cyc == 5) rst_n = 1'b1;
            nv += int'(valid);
            nd += int'(done);
        end
        for (int i = 0; i < N; i++) begin
            mphase[i] = '0;
            mstep[i]  = '0;
        end
        chk("reset_mid_valid", 32'(nv), 32'(0));
        chk("reset_mid_done", 32'(nd), 32'(0));
        chk("reset_mid_busy", 32'(busy), 32'(0));
        chk("reset_mid_overrun", 32'(ovr), 32'(0));
        for (int i = 0; i < N; i++) cfg_write(i, 24'($urandom));
        run_frame(1'b0, 1'b0);
        for (int i = 0; i < N; i++) chk($sformatf("restart_arg%0d", i), 32'(obs_args[i]), 32'(0));
        run_frame(1'b1, 1'b0);

`ifdef OCTANE_PHASE_MOD_EN
        reset_dut();
        cfg_write(0, 24'h000800);
        run_frame(1'b0, 1'b0);
        cfg_write(0, 24'h000000);
        pm = 13'h1FFF;
        run_frame(1'b0, 1'b0);
        chk("phase_mod_wrap", 32'(obs_args[0]), 32'h0000);
        pm = 13'h0000;
        run_frame(1'b0, 1'b0);
        chk("phase_mod_no_store", 32'(obs_args[0]), 32'h0001);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
